// File: rtl/servo_pkg.sv
// Shared servo definitions: command type, stop encoding and default PWM timing
// constants, also used by the line-follower steering FSM.
package servo_pkg;

    localparam int SERVO_CMD_W = 8;
    typedef logic [SERVO_CMD_W-1:0] servo_cmd_t;

    localparam servo_cmd_t SERVO_STOP = '0;

    localparam int US_CNT_W = 15;
    localparam int WIDTH_W  = 16;

    localparam int DEF_TICK_DIV      = 100;
    localparam int DEF_FRAME_US      = 20000;
    localparam int DEF_PULSE_MIN_US  = 1000;
    localparam int DEF_PULSE_STEP_US = 4;
    localparam int DEF_RAMP_STEP     = 8;

    // Pulse width in us ticks; wraps silently in 16 bits, parameters keep it in range.
    function automatic logic [WIDTH_W-1:0] pulse_width(input servo_cmd_t cmd,
                                                       input int min_us,
                                                       input int step_us);
        return WIDTH_W'(min_us) + WIDTH_W'(cmd) * WIDTH_W'(step_us);
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo output: frame-sampled shadow command, pulse-width arithmetic and
// registered comparator. SERVO_PWM_RAMP_EN enables per-frame slew limiting.
module servo_pwm_channel
    import servo_pkg::*;
#(
    parameter int PULSE_MIN_US  = DEF_PULSE_MIN_US,
    parameter int PULSE_STEP_US = DEF_PULSE_STEP_US
`ifdef SERVO_PWM_RAMP_EN
    ,
    parameter int RAMP_STEP     = DEF_RAMP_STEP
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                frame_end,
    input  logic [US_CNT_W-1:0] us_cnt,
    input  logic [7:0]          cmd,
    output logic                pwm
);

    servo_cmd_t         shadow;
    servo_cmd_t         shadow_nxt;
    logic [WIDTH_W-1:0] width;

`ifdef SERVO_PWM_RAMP_EN
    localparam logic signed [SERVO_CMD_W:0] STEP9 = (SERVO_CMD_W+1)'(RAMP_STEP);
    localparam servo_cmd_t                  STEP8 = SERVO_CMD_W'(RAMP_STEP);

    logic signed [SERVO_CMD_W:0] diff;

    // Stop is applied at once and a start from stop is direct; only running
    // speed changes are slewed, and never past the command.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        shadow_nxt = cmd;
        diff       = $signed({1'b0, cmd}) - $signed({1'b0, shadow});
        if (cmd == SERVO_STOP) begin
            shadow_nxt = SERVO_STOP;
        end else if (shadow == SERVO_STOP) begin
            shadow_nxt = cmd;
        end else if (diff > STEP9) begin
            shadow_nxt = shadow + STEP8;
        end else if (diff < -STEP9) begin
            shadow_nxt = shadow - STEP8;
        end
    end
`else
    assign shadow_nxt = cmd;
`endif

    assign width = pulse_width(shadow, PULSE_MIN_US, PULSE_STEP_US);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the shadow is a plain register, so it is reset with everything else.
            shadow <= SERVO_STOP;
            pwm    <= 1'b0;
        end else if (!en) begin
            shadow <= SERVO_STOP;
            pwm    <= 1'b0;
        end else begin
            if (frame_end) begin
                shadow <= shadow_nxt;
            end
            pwm <= (shadow != SERVO_STOP) && ({1'b0, us_cnt} < width);
        end
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// Two-channel hobby-servo PWM generator: us prescaler, frame counter and frame
// strobe, driving two servo_pwm_channel instances. Optional macro: SERVO_PWM_RAMP_EN.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int FRAME_US      = DEF_FRAME_US,
    parameter int PULSE_MIN_US  = DEF_PULSE_MIN_US,
    parameter int PULSE_STEP_US = DEF_PULSE_STEP_US,
    parameter int RAMP_STEP     = DEF_RAMP_STEP
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] servo_l,
    input  logic [7:0] servo_r,
    output logic       pwm_l,
    output logic       pwm_r,
    output logic       frame_start
);

    localparam int                     PRE_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]       PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [US_CNT_W-1:0]    US_LAST  = US_CNT_W'(FRAME_US - 1);

    if (TICK_DIV < 2 || FRAME_US > 2**US_CNT_W || RAMP_STEP < 1 || RAMP_STEP > 255 ||
        FRAME_US <= PULSE_MIN_US + (2**SERVO_CMD_W - 1) * PULSE_STEP_US) begin : g_param_check
        $error("servo_pwm_gen: invalid parameter set");
    end

    logic [PRE_W-1:0]    prescaler;
    logic [US_CNT_W-1:0] us_cnt;
    logic                run;
    logic                tick;
    logic                frame_end;

    assign tick      = run && (prescaler == PRE_LAST);
    assign frame_end = tick && (us_cnt == US_LAST);

    // The counters idle at zero for one edge after reset or enable so that the
    // first frame opens with a frame_start cycle just like every later frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler   <= '0;
            us_cnt      <= '0;
            run         <= 1'b0;
            frame_start <= 1'b0;
        end else if (!en) begin
            prescaler   <= '0;
            us_cnt      <= '0;
            run         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            run         <= 1'b1;
            frame_start <= !run || frame_end;
            if (run) begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
                if (frame_end) begin
                    us_cnt <= '0;
                end else if (tick) begin
                    us_cnt <= us_cnt + 1'b1;
                end
            end
        end
    end

    servo_pwm_channel #(
        .PULSE_MIN_US  (PULSE_MIN_US),
        .PULSE_STEP_US (PULSE_STEP_US)
`ifdef SERVO_PWM_RAMP_EN
        ,
        .RAMP_STEP     (RAMP_STEP)
`endif
    ) u_chan_l (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .frame_end (frame_end),
        .us_cnt    (us_cnt),
        .cmd       (servo_l),
        .pwm       (pwm_l)
    );

    servo_pwm_channel #(
        .PULSE_MIN_US  (PULSE_MIN_US),
        .PULSE_STEP_US (PULSE_STEP_US)
`ifdef SERVO_PWM_RAMP_EN
        ,
        .RAMP_STEP     (RAMP_STEP)
`endif
    ) u_chan_r (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .frame_end (frame_end),
        .us_cnt    (us_cnt),
        .cmd       (servo_r),
        .pwm       (pwm_r)
    );

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen: per-frame pulse measurement against a
// frame-level model of the shadow commands (ramp rules when SERVO_PWM_RAMP_EN).
module tb_servo_pwm_gen;

    localparam int TICK_DIV      = 2;
    localparam int FRAME_US      = 3000;
    localparam int PULSE_MIN_US  = 1000;
    localparam int PULSE_STEP_US = 4;
    localparam int RAMP_STEP     = 8;
    localparam int FRAME_CYC     = FRAME_US * TICK_DIV;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] servo_l;
    logic [7:0] servo_r;
    logic       pwm_l;
    logic       pwm_r;
    logic       frame_start;

    int tests = 0;
    int fails = 0;
    int sh_l  = 0;
    int sh_r  = 0;

    servo_pwm_gen #(
        .TICK_DIV      (TICK_DIV),
        .FRAME_US      (FRAME_US),
        .PULSE_MIN_US  (PULSE_MIN_US),
        .PULSE_STEP_US (PULSE_STEP_US),
        .RAMP_STEP     (RAMP_STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .servo_l     (servo_l),
        .servo_r     (servo_r),
        .pwm_l       (pwm_l),
        .pwm_r       (pwm_r),
        .frame_start (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Shadow value the next frame uses, given this frame's shadow and the command at frame end.
    function automatic int next_shadow(input int sh, input int cmd);
`ifdef SERVO_PWM_RAMP_EN
        if (cmd == 0) return 0;
        if (sh == 0) return cmd;
        if (cmd > sh) return (cmd - sh > RAMP_STEP) ? sh + RAMP_STEP : cmd;
        return (sh - cmd > RAMP_STEP) ? sh - RAMP_STEP : cmd;
`else
        return sh * 0 + cmd;
`endif
    endfunction

    function automatic int exp_cycles(input int sh);
        return (sh == 0) ? 0 : (PULSE_MIN_US + sh * PULSE_STEP_US) * TICK_DIV;
    endfunction

    // Waits (bounded) for frame_start; returns the number of negedges taken, or -1.
    task automatic wait_fs(output int n);
        n = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Called at the negedge of a frame_start cycle; measures one whole frame and
    // leaves the bench at the negedge of the next frame_start cycle.
    task automatic run_frame(input string tag, input int new_l, input int new_r, input int chg_at);
        int hi_l = 0, hi_r = 0;
        int first_l = -1, last_l = -1, first_r = -1, last_r = -1;
        int fs_mid = 0, fs_end = 0;
        int exp_l, exp_r;
        exp_l = exp_cycles(sh_l);
        exp_r = exp_cycles(sh_r);
        for (int k = 1; k <= FRAME_CYC; k++) begin
            @(negedge clk);
            if (k < FRAME_CYC) begin
                if (pwm_l === 1'b1) begin
                    hi_l++;
                    if (first_l < 0) first_l = k;
                    last_l = k;
                end
                if (pwm_r === 1'b1) begin
                    hi_r++;
                    if (first_r < 0) first_r = k;
                    last_r = k;
                end
                if (frame_start !== 1'b0) fs_mid++;
            end else begin
                fs_end = (frame_start === 1'b1) ? 1 : 0;
            end
            if (k == chg_at) begin
                servo_l = 8'(new_l);
                servo_r = 8'(new_r);
            end
        end
        check({tag, "_len_l"}, hi_l, exp_l);
        check({tag, "_len_r"}, hi_r, exp_r);
        check({tag, "_span_l"}, (first_l < 0) ? 0 : last_l - first_l + 1, exp_l);
        check({tag, "_span_r"}, (first_r < 0) ? 0 : last_r - first_r + 1, exp_r);
        check({tag, "_rise_l"}, first_l, (exp_l > 0) ? 1 : -1);
        check({tag, "_rise_r"}, first_r, (exp_r > 0) ? 1 : -1);
        check({tag, "_fs_mid"}, fs_mid, 0);
        check({tag, "_fs_period"}, fs_end, 1);
        sh_l = next_shadow(sh_l, int'(servo_l));
        sh_r = next_shadow(sh_r, int'(servo_r));
    endtask

    initial begin
        int n;
        int quiet;

        rst     = 1'b0;
        en      = 1'b1;
        servo_l = 8'd155;
        servo_r = 8'd137;
        repeat (3) @(negedge clk);
        check("reset_pwm_l", pwm_l, 0);
        check("reset_pwm_r", pwm_r, 0);
        check("reset_frame_start", frame_start, 0);

        // Test 1/2/3: first frame silent, then pulses; mid-pulse command change; stop.
        rst = 1'b1;
        wait_fs(n);
        check("t1_fs_latency", n, 1);
        sh_l = 0;
        sh_r = 0;
        run_frame("t1_f1", 0, 0, 0);
        run_frame("t2_f2", 255, 137, 500);
        run_frame("t3_f3", 255, 0, 100);
        run_frame("t3_f4", 255, 60, 200);

        // Test 4: enable dropped mid-pulse for 10 cycles.
        repeat (100) @(negedge clk);
        check("t4_pre_pwm_l", pwm_l, 1);
        check("t4_pre_pwm_r", pwm_r, 1);
        en = 1'b0;
        @(negedge clk);
        check("t4_off_pwm_l", pwm_l, 0);
        check("t4_off_pwm_r", pwm_r, 0);
        check("t4_off_fs", frame_start, 0);
        quiet = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (pwm_l !== 1'b0 || pwm_r !== 1'b0 || frame_start !== 1'b0) quiet++;
        end
        check("t4_off_quiet", quiet, 0);
        en   = 1'b1;
        sh_l = 0;
        sh_r = 0;
        wait_fs(n);
        check("t4_fs_latency", n, 1);
        run_frame("t4_f1", 0, 0, 0);
        run_frame("t4_f2", 0, 0, 0);

        // Test 5: asynchronous reset between clock edges during a pulse.
        repeat (50) @(negedge clk);
        check("t5_pre_pwm_l", pwm_l, 1);
        #1 rst = 1'b0;
        #1;
        check("t5_async_pwm_l", pwm_l, 0);
        check("t5_async_pwm_r", pwm_r, 0);
        check("t5_async_fs", frame_start, 0);
        repeat (3) @(negedge clk);
        rst  = 1'b1;
        sh_l = 0;
        sh_r = 0;
        wait_fs(n);
        check("t5_fs_latency", n, 1);

        // Test 6 plus random right-channel commands: 100 -> 130 (slewed with ramp) -> 0.
        run_frame("t6_f0", 100, $urandom_range(0, 255), $urandom_range(1, FRAME_CYC - 1));
        run_frame("t6_f1", 130, $urandom_range(0, 255), $urandom_range(1, FRAME_CYC - 1));
        run_frame("t6_f2", 130, $urandom_range(0, 255), $urandom_range(1, FRAME_CYC - 1));
        run_frame("t6_f3", 130, $urandom_range(0, 255), $urandom_range(1, FRAME_CYC - 1));
        run_frame("t6_f4", 130, $urandom_range(0, 255), $urandom_range(1, FRAME_CYC - 1));
        run_frame("t6_f5", 0, $urandom_range(0, 255), $urandom_range(1, FRAME_CYC - 1));
        run_frame("t6_f6", 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
